// File: rtl/operand_stage_pkg.sv
// Shared definitions for the operand stage.
// Contents:
//   - the opcode values the stage decodes
//   - the ALU SELECT codes
//   - the execute latency constants
//   - the FSM state encoding
//   - a helper that classifies an opcode as legal or illegal
package operand_stage_pkg;

  // Supported opcodes. Every other value in the 8-bit opcode field is illegal.
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // ALU operation select codes.
  // Subtraction uses the adder: the stage negates operand 2 before it
  // reaches the ALU.
  localparam logic [2:0] SEL_PASS  = 3'b000;
  localparam logic [2:0] SEL_ADD   = 3'b001;
  localparam logic [2:0] SEL_AND   = 3'b010;
  localparam logic [2:0] SEL_OR    = 3'b011;

  // Number of EXEC cycles spent waiting for the ALU result.
  localparam logic [1:0] LAT_SHORT = 2'd1;
  localparam logic [1:0] LAT_LONG  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Legal opcodes are contiguous, from OP_LOADI up to OP_OR.
  function automatic logic is_legal(input logic [7:0] op);
    return (op <= OP_OR);
  endfunction

endpackage

// File: rtl/operand_stage_reg_file8x8.sv
// reg_file8x8: eight 8-bit registers.
// Ports:
//   clk, reset            - rising-edge clock; asynchronous clear, active low
//   we, waddr, wdata      - synchronous write port
//   rt_addr -> rt_data    - combinational read port for operand 1
//   rs_addr -> rs_data    - combinational read port for operand 2
//   dbg_addr -> dbg_data  - combinational read port for debug
module reg_file8x8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] rt_addr,
  output logic [7:0] rt_data,
  input  logic [2:0] rs_addr,
  output logic [7:0] rs_data,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  logic [7:0] mem [8];

  // Storage array. Reset clears every entry so that no stale operands
  // remain after an aborted instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rt_data  = mem[rt_addr];
  assign rs_data  = mem[rs_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/operand_stage.sv
// operand_stage: decodes one instruction and presents its operands to an
// external ALU. It then waits a fixed latency and writes the returned result
// back into the register file.
// Ports:
//   clk, reset               - rising-edge clock; asynchronous reset, active low
//   instr, instr_valid       - instruction word and its valid flag
//   instr_ready              - high only while the stage is idle
//   wb_data                  - ALU result, written to reg[RD] when leaving WRITE
//   data1, data2, select     - registered ALU operands and operation select
//   out_valid                - operands valid, from acceptance to writeback
//   illegal                  - one-cycle pulse for an unsupported opcode
//   dbg_addr -> dbg_data     - combinational register-file read
module operand_stage
  import operand_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [7:0]  wb_data,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic [2:0]  select,
  output logic        out_valid,
  output logic        illegal,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  // Instruction fields. RS overlaps the low bits of the immediate.
  logic [7:0] opcode;
  logic [2:0] rd, rt, rs;
  logic [7:0] imm;
  logic       unused_instr_bits;

  assign opcode = instr[31:24];
  assign rd     = instr[18:16];
  assign rt     = instr[10:8];
  assign imm    = instr[7:0];
  assign rs     = imm[2:0];
  assign unused_instr_bits = ^{instr[23:19], instr[15:11]};

  state_t     state, state_nxt;
  logic [1:0] cnt;
  logic [2:0] rd_q;
  logic       rf_we;
  logic [7:0] rt_data, rs_data;
  logic       accept, reject;

  // Instructions are only looked at while idle; anything offered in EXEC or
  // WRITE is ignored.
  assign accept = (state == ST_IDLE) && instr_valid &&  is_legal(opcode);
  assign reject = (state == ST_IDLE) && instr_valid && !is_legal(opcode);

  reg_file8x8 u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (wb_data),
    .rt_addr  (rt),
    .rt_data  (rt_data),
    .rs_addr  (rs),
    .rs_data  (rs_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Operand decode from the current register contents. The results are
  // captured only when an instruction is accepted.
  logic [7:0] data2_dec;
  logic [2:0] sel_dec;
  logic [1:0] lat_dec;

  always_comb begin
    data2_dec = rs_data;
    sel_dec   = SEL_PASS;
    lat_dec   = LAT_SHORT;
    case (opcode)
      OP_LOADI: data2_dec = imm;
      OP_MOV:   sel_dec   = SEL_PASS;
      OP_ADD: begin
        sel_dec = SEL_ADD;
        lat_dec = LAT_LONG;
      end
      OP_SUB: begin
        // Two's-complement negate; 0x80 and 0x00 map to themselves.
        data2_dec = (~rs_data) + 8'd1;
        sel_dec   = SEL_ADD;
        lat_dec   = LAT_LONG;
      end
      OP_AND:  sel_dec = SEL_AND;
      OP_OR:   sel_dec = SEL_OR;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. EXEC ends on the edge where the counter goes from 1
  // to 0, so EXEC lasts exactly LAT cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_EXEC;
      ST_EXEC:  if (cnt == 2'd1) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    case (state)
      ST_IDLE:  instr_ready = 1'b1;
      ST_WRITE: rf_we       = 1'b1;
      default:  ;
    endcase
  end

  // Operand and control registers.
  // data1, data2 and select keep their last values after writeback. An
  // illegal opcode only raises the illegal pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data1     <= 8'h00;
      data2     <= 8'h00;
      select    <= 3'b000;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= 2'd0;
      rd_q      <= 3'd0;
    end else begin
      illegal <= reject;
      if (accept) begin
        data1     <= rt_data;
        data2     <= data2_dec;
        select    <= sel_dec;
        out_valid <= 1'b1;
        cnt       <= lat_dec;
        rd_q      <= rd;
      end else if (state == ST_EXEC) begin
        cnt <= cnt - 2'd1;
      end else if (state == ST_WRITE) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Directed testbench for operand_stage. Each task drives one scenario and
// checks the results against hand-computed values.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  wb_data;
  logic [7:0]  data1, data2;
  logic [2:0]  select;
  logic        out_valid;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int total = 0;
  int bad   = 0;

  // Expected register-file contents, updated by hand as each test writes.
  logic [7:0] exp_regs [8];

  operand_stage dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .wb_data     (wb_data),
    .data1       (data1),
    .data2       (data2),
    .select      (select),
    .out_valid   (out_valid),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Watchdog: stop the run if it never reaches the summary line.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present an instruction for exactly one edge (E0). Afterwards, drive
  // junk so the DUT cannot depend on instr being held.
  task automatic send(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    tick(1);
    instr_valid = 1'b0;
    instr       = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    instr = 32'h0;
    instr_valid = 1'b0;
    wb_data = 8'h00;
    dbg_addr = 3'd0;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      exp_regs[i] = 8'h00;
      dbg_addr = 3'(i);
      #1;
      total++;
      if (dbg_data !== 8'h00) begin
        bad++;
        $display("[TB] FAIL reset_reg%0d: actual=%h required=00", i, dbg_data);
      end
    end
    total++;
    if ({instr_ready, out_valid, illegal} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: actual rdy/ov/ill=%b required=100",
               {instr_ready, out_valid, illegal});
    end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_loadi;
    // loadi r1, 0x05
    send(32'h0001_0005);
    wb_data = 8'h05;
    total++;
    if ({data1, data2, select, out_valid, instr_ready} !== {8'h00, 8'h05, 3'b000, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL loadi_e0: actual d1=%h d2=%h sel=%b ov=%b rdy=%b required 00 05 000 1 0",
               data1, data2, select, out_valid, instr_ready);
    end
    tick(1);
    total++;
    if ({out_valid, instr_ready} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL loadi_e1: actual ov/rdy=%b required=10", {out_valid, instr_ready});
    end
    tick(1);
    exp_regs[1] = 8'h05;
    dbg_addr = 3'd1;
    #1;
    total++;
    if ({dbg_data, out_valid, instr_ready} !== {8'h05, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL loadi_e2: actual r1=%h ov=%b rdy=%b required 05 0 1",
               dbg_data, out_valid, instr_ready);
    end
    // loadi r2, 0x07
    send(32'h0002_0007);
    wb_data = 8'h07;
    tick(2);
    exp_regs[2] = 8'h07;
    dbg_addr = 3'd2;
    #1;
    total++;
    if (dbg_data !== 8'h07) begin
      bad++;
      $display("[TB] FAIL loadi_r2: actual=%h required=07", dbg_data);
    end
  endtask

  task automatic test_sub;
    // sub r3, r1, r2 with r1=05, r2=07 gives data2 = -7 = F9
    send(32'h0303_0102);
    wb_data = 8'hFE;
    total++;
    if ({data1, data2, select, out_valid} !== {8'h05, 8'hF9, 3'b001, 1'b1}) begin
      bad++;
      $display("[TB] FAIL sub_ops: actual d1=%h d2=%h sel=%b ov=%b required 05 F9 001 1",
               data1, data2, select, out_valid);
    end
    tick(1);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sub_e1: actual ov=%b required=1", out_valid);
    end
    tick(1);
    dbg_addr = 3'd3;
    #1;
    total++;
    if ({out_valid, instr_ready, dbg_data} !== {1'b1, 1'b0, 8'h00}) begin
      bad++;
      $display("[TB] FAIL sub_e2: actual ov=%b rdy=%b r3=%h required 1 0 00",
               out_valid, instr_ready, dbg_data);
    end
    tick(1);
    exp_regs[3] = 8'hFE;
    #1;
    total++;
    if ({out_valid, instr_ready, dbg_data, data2, select} !== {1'b0, 1'b1, 8'hFE, 8'hF9, 3'b001}) begin
      bad++;
      $display("[TB] FAIL sub_e3: actual ov=%b rdy=%b r3=%h d2=%h sel=%b required 0 1 FE F9 001",
               out_valid, instr_ready, dbg_data, data2, select);
    end
  endtask

  task automatic test_sub_edge;
    // r2 = 0x80, then sub: the negation of 0x80 is 0x80
    send(32'h0002_0080);
    wb_data = 8'h80;
    tick(2);
    exp_regs[2] = 8'h80;
    send(32'h0303_0102);
    wb_data = 8'h85;
    total++;
    if ({data1, data2} !== {8'h05, 8'h80}) begin
      bad++;
      $display("[TB] FAIL sub_80: actual d1=%h d2=%h required 05 80", data1, data2);
    end
    tick(3);
    exp_regs[3] = 8'h85;
    // r2 = 0x00, then sub: the negation of 0x00 is 0x00
    send(32'h0002_0000);
    wb_data = 8'h00;
    tick(2);
    exp_regs[2] = 8'h00;
    send(32'h0303_0102);
    wb_data = 8'h0C;
    total++;
    if ({data2, select} !== {8'h00, 3'b001}) begin
      bad++;
      $display("[TB] FAIL sub_00: actual d2=%h sel=%b required 00 001", data2, select);
    end
    tick(3);
    exp_regs[3] = 8'h0C;
    dbg_addr = 3'd3;
    #1;
    total++;
    if (dbg_data !== 8'h0C) begin
      bad++;
      $display("[TB] FAIL sub_00_wb: actual r3=%h required 0C", dbg_data);
    end
  endtask

  task automatic test_mov_and_or;
    // mov r5, r1 : d1=r0=00, d2=r1=05
    send(32'h0105_0001);
    wb_data = 8'h05;
    total++;
    if ({data1, data2, select} !== {8'h00, 8'h05, 3'b000}) begin
      bad++;
      $display("[TB] FAIL mov: actual d1=%h d2=%h sel=%b required 00 05 000", data1, data2, select);
    end
    tick(2);
    exp_regs[5] = 8'h05;
    // and r6, r3, r1 : d1=0C, d2=05
    send(32'h0406_0301);
    wb_data = 8'h04;
    total++;
    if ({data1, data2, select} !== {8'h0C, 8'h05, 3'b010}) begin
      bad++;
      $display("[TB] FAIL and: actual d1=%h d2=%h sel=%b required 0C 05 010", data1, data2, select);
    end
    tick(1);
    total++;
    if ({out_valid, instr_ready} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL and_lat: actual ov/rdy=%b required=10", {out_valid, instr_ready});
    end
    tick(1);
    exp_regs[6] = 8'h04;
    // or r7, r6, r3 : d1=04, d2=0C
    send(32'h0507_0603);
    wb_data = 8'h0C;
    total++;
    if ({data1, data2, select} !== {8'h04, 8'h0C, 3'b011}) begin
      bad++;
      $display("[TB] FAIL or: actual d1=%h d2=%h sel=%b required 04 0C 011", data1, data2, select);
    end
    tick(2);
    exp_regs[7] = 8'h0C;
    dbg_addr = 3'd7;
    #1;
    total++;
    if ({dbg_data, instr_ready} !== {8'h0C, 1'b1}) begin
      bad++;
      $display("[TB] FAIL or_wb: actual r7=%h rdy=%b required 0C 1", dbg_data, instr_ready);
    end
  endtask

  task automatic test_back_to_back;
    // add r1, r1, r1, with a competing instruction offered during EXEC
    send(32'h0201_0101);
    wb_data = 8'h0A;
    total++;
    if ({data1, data2, select} !== {8'h05, 8'h05, 3'b001}) begin
      bad++;
      $display("[TB] FAIL add_same: actual d1=%h d2=%h sel=%b required 05 05 001", data1, data2, select);
    end
    instr = 32'h0000_0099;
    instr_valid = 1'b1;
    tick(1);
    instr_valid = 1'b0;
    total++;
    if ({data1, data2, out_valid} !== {8'h05, 8'h05, 1'b1}) begin
      bad++;
      $display("[TB] FAIL ignore_busy: actual d1=%h d2=%h ov=%b required 05 05 1", data1, data2, out_valid);
    end
    tick(2);
    exp_regs[1] = 8'h0A;
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_ready: actual=%b required=1", instr_ready);
    end
    // mov r0, r1 issued immediately; it must see the new r1
    send(32'h0100_0001);
    total++;
    if ({data1, data2} !== {8'h00, 8'h0A}) begin
      bad++;
      $display("[TB] FAIL b2b_hazard: actual d1=%h d2=%h required 00 0A", data1, data2);
    end
    tick(2);
    exp_regs[0] = 8'h0A;
    dbg_addr = 3'd0;
    #1;
    total++;
    if (dbg_data !== 8'h0A) begin
      bad++;
      $display("[TB] FAIL b2b_wb: actual r0=%h required 0A", dbg_data);
    end
  endtask

  task automatic test_illegal;
    wb_data = 8'hEE;
    send(32'h0700_0000);
    total++;
    if ({illegal, instr_ready, out_valid} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL illegal_pulse: actual ill/rdy/ov=%b required=110",
               {illegal, instr_ready, out_valid});
    end
    total++;
    if ({data1, data2, select} !== {8'h00, 8'h0A, 3'b000}) begin
      bad++;
      $display("[TB] FAIL illegal_hold: actual d1=%h d2=%h sel=%b required 00 0A 000", data1, data2, select);
    end
    tick(1);
    total++;
    if ({illegal, instr_ready, out_valid} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL illegal_end: actual ill/rdy/ov=%b required=010",
               {illegal, instr_ready, out_valid});
    end
    tick(2);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      total++;
      if (dbg_data !== exp_regs[i]) begin
        bad++;
        $display("[TB] FAIL illegal_reg%0d: actual=%h required=%h", i, dbg_data, exp_regs[i]);
      end
    end
  endtask

  task automatic test_reset_abort;
    // add r4, r1, r2, aborted one cycle into EXEC
    send(32'h0204_0102);
    wb_data = 8'h77;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_start: actual ov=%b required=1", out_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({data1, data2, select, out_valid, illegal, instr_ready} !== {8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL abort_outputs: actual d1=%h d2=%h sel=%b ov=%b ill=%b rdy=%b required 00 00 000 0 0 1",
               data1, data2, select, out_valid, illegal, instr_ready);
    end
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    tick(3);
    dbg_addr = 3'd4;
    #1;
    total++;
    if ({dbg_data, instr_ready, out_valid} !== {8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL abort_after: actual r4=%h rdy=%b ov=%b required 00 1 0",
               dbg_data, instr_ready, out_valid);
    end
    // operation resumes normally: loadi r4, 0x33
    send(32'h0004_0033);
    wb_data = 8'h33;
    tick(2);
    #1;
    total++;
    if (dbg_data !== 8'h33) begin
      bad++;
      $display("[TB] FAIL abort_resume: actual r4=%h required 33", dbg_data);
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    test_reset();
    test_loadi();
    test_sub();
    test_sub_edge();
    test_mov_and_or();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Ports SHALL be, clock and reset first: CLK, input, 1, rising-edge clock.
REQ-002 RESET, input, 1: asynchronous, active-low reset.
REQ-003 INSTR, input, 32: instruction word {OP[31:24], RD[18:16], RT[10:8], RS/IMM[7:0]}; RS = IMM[2:0].
REQ-004 INSTR_VALID, input, 1: INSTR is presented.
REQ-005 INSTR_READY, output, 1: stage accepts an instruction this cycle.
REQ-006 WB_DATA, input, 8: ALU RESULT returned for writeback.
REQ-007 DATA1, output, 8: ALU operand 1.
REQ-008 DATA2, output, 8: ALU operand 2.
REQ-009 SELECT, output, 3: ALU operation select.
REQ-010 OUT_VALID, output, 1: DATA1, DATA2 and SELECT are valid.
REQ-011 ILLEGAL, output, 1: one-cycle pulse on an unsupported opcode.
REQ-012 DBG_ADDR, input, 3, and DBG_DATA, output, 8: combinational debug read of the register file.

Function
REQ-013 Opcodes SHALL be loadi=0x00, mov=0x01, add=0x02, sub=0x03, and=0x04, or=0x05; all other values are illegal.
REQ-014 SELECT SHALL be 000 for loadi and mov, 001 for add and sub, 010 for and, 011 for or.
REQ-015 DATA2 SHALL be IMM for loadi, reg[RS] for mov, and, or and add, and (~reg[RS]+1) mod 256 for sub; 0x80 therefore maps to 0x80.
REQ-016 DATA1 SHALL be reg[RT] for all legal opcodes, including loadi and mov.
REQ-017 The FSM SHALL have three states: IDLE, EXEC and WRITE. INSTR_READY=1 only in IDLE.
REQ-018 IDLE: when INSTR_VALID=1 with a legal opcode at an edge E0, the stage SHALL register DATA1, DATA2 and SELECT from the current register contents, latch RD, set OUT_VALID=1, load the latency counter with LAT and enter EXEC.
REQ-019 LAT SHALL be 1 for loadi, mov, and and or, and 2 for add and sub.
REQ-020 EXEC SHALL decrement the counter on each edge and enter WRITE when the counter reaches 0, so EXEC lasts exactly LAT cycles.
REQ-021 WRITE SHALL last one cycle; at the edge leaving WRITE the stage writes reg[RD] <= WB_DATA, clears OUT_VALID and enters IDLE.
REQ-022 Accept-to-write SHALL be LAT+1 edges, and INSTR_READY SHALL be high again in the cycle after the write.
REQ-023 DATA1, DATA2 and SELECT SHALL hold their values from E0 until the write edge; after the write they retain their last values.
REQ-024 An illegal opcode accepted in IDLE SHALL pulse ILLEGAL for exactly one cycle, leave the FSM in IDLE, and change neither the registers nor the outputs.
REQ-025 INSTR_VALID outside IDLE SHALL be ignored; INSTR need not be held after acceptance.
REQ-026 Operands SHALL be read at acceptance, so identical RD, RT and RS are legal, and a following instruction SHALL observe the written value with no hazard.
REQ-027 DBG_DATA SHALL equal reg[DBG_ADDR] combinationally, showing the new value after the write edge.

Reset
REQ-028 RESET=0 SHALL immediately force IDLE, clear all eight registers, DATA1, DATA2, SELECT, OUT_VALID, ILLEGAL and the counter to 0, and set INSTR_READY=1.
REQ-029 Reset during EXEC or WRITE SHALL abort the instruction with no register write; operation resumes at the first edge after RESET returns to 1.

Structure
REQ-030 A shared package SHALL hold the opcode constants, the ALU SELECT codes, the LAT constants and the FSM state encoding.
REQ-031 The register file SHALL be one sub-module, reg_file8x8: 8x8 storage, three combinational read ports (RT, RS, DBG), one synchronous write port, and asynchronous active-low clear.

Verification
REQ-032 Reset: after RESET, DBG_DATA SHALL read 0x00 for addresses 0-7, with INSTR_READY=1, OUT_VALID=0 and ILLEGAL=0.
REQ-033 loadi: INSTR=0x00010005 -> after E0, SELECT=000, DATA2=0x05 and OUT_VALID=1 for 2 cycles; with WB_DATA=0x05, reg1=0x05 at E2 and INSTR_READY=1 in the next cycle.
REQ-034 sub: with r1=0x05 and r2=0x07, INSTR=0x03030102 -> DATA1=0x05, DATA2=0xF9, SELECT=001, OUT_VALID=1 for 3 cycles; WB_DATA=0xFE gives r3=0xFE at E3.
REQ-035 sub edge case: r2=0x80 gives DATA2=0x80; r2=0x00 gives DATA2=0x00.
REQ-036 Illegal: INSTR=0x07000000 -> ILLEGAL=1 for one cycle, INSTR_READY stays 1 and all registers are unchanged.
REQ-037 Reset abort: assert RESET one cycle into EXEC of add r4,r1,r2 -> all outputs are 0 immediately, r4 stays 0x00, and the FSM is in IDLE after release.
